// File: rtl/rc2014_mem_window.sv
// RC2014 bus memory window: decodes a 2^ADDR_BITS window at BASE_ADDR and serves it from a sync memory port.
// Define ACCESS_COUNT_EN to add read/write access counters and a sticky write-protect violation flag.
module rc2014_mem_window #(
  parameter logic [15:0] BASE_ADDR        = 16'h0000,
  parameter int          ADDR_BITS        = 13,
  parameter bit          WRITABLE         = 1'b0,
  parameter int          SYNC_STAGES      = 2,
  parameter int          LED_STRETCH_BITS = 24
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [15:0]          A,
  input  logic [7:0]           D_IN,
  output logic [7:0]           D_OUT,
  output logic                 DATA_DIR,
  input  logic                 MRQ,
  input  logic                 RD,
  input  logic                 WR,
  input  logic                 BUT1,
  output logic                 LED1,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_re,
  input  logic [7:0]           mem_rdata,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata
`ifdef ACCESS_COUNT_EN
  ,
  output logic [15:0]          read_count,
  output logic [15:0]          write_count,
  output logic                 wp_violation
`endif
);

  localparam int SYNC_W = 28;
  // Chain word layout: {BUT1, WR, RD, MRQ, D_IN, A}; idle has all strobes released.
  localparam logic [SYNC_W-1:0] SYNC_IDLE = {4'hF, 24'h000000};

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  logic [SYNC_W-1:0]           sync_q [SYNC_STAGES];
  logic [SYNC_W-1:0]           sync_d [SYNC_STAGES];
  state_t                      state_q, state_d;
  logic [7:0]                  dout_q, dout_d;
  logic                        dir_q, dir_d;
  logic [ADDR_BITS-1:0]        maddr_q, maddr_d;
  logic                        re_q, re_d;
  logic                        we_q, we_d;
  logic [7:0]                  wdata_q, wdata_d;
  logic [LED_STRETCH_BITS-1:0] led_q, led_d;
  logic                        rd_entry, wr_entry;

  logic [15:0] a_s;
  logic [7:0]  d_s;
  logic        mrq_s, rd_s, wr_s, but_s, hit;

  assign a_s   = sync_q[SYNC_STAGES-1][15:0];
  assign d_s   = sync_q[SYNC_STAGES-1][23:16];
  assign mrq_s = sync_q[SYNC_STAGES-1][24];
  assign rd_s  = sync_q[SYNC_STAGES-1][25];
  assign wr_s  = sync_q[SYNC_STAGES-1][26];
  assign but_s = sync_q[SYNC_STAGES-1][27];
  assign hit   = (a_s[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]) && !mrq_s;

  always_comb begin
    sync_d[0] = {BUT1, WR, RD, MRQ, D_IN, A};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    dir_d    = dir_q;
    maddr_d  = maddr_q;
    re_d     = 1'b0;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    rd_entry = 1'b0;
    wr_entry = 1'b0;
    case (state_q)
      IDLE: begin
        dir_d = 1'b0;
        if (hit && !rd_s && wr_s) begin
          state_d  = READ;
          maddr_d  = a_s[ADDR_BITS-1:0];
          re_d     = 1'b1;
          rd_entry = 1'b1;
        end else if (hit && !wr_s && rd_s && WRITABLE) begin
          state_d  = WRITE;
          maddr_d  = a_s[ADDR_BITS-1:0];
          wdata_d  = d_s;
          wr_entry = 1'b1;
        end
      end
      READ: begin
        // Keep refreshing D_OUT so the pad follows the memory once its read latency settles.
        if (rd_s || mrq_s) begin
          dir_d   = 1'b0;
          state_d = IDLE;
        end else begin
          dir_d  = 1'b1;
          dout_d = mem_rdata;
        end
      end
      WRITE: begin
        if (wr_s || mrq_s) begin
          we_d    = 1'b1;
          state_d = DONE;
        end else begin
          wdata_d = d_s;
        end
      end
      DONE: begin
        // Hold here until both strobes release so a lingering WR cannot retrigger a write.
        if (wr_s && rd_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    led_d = led_q;
    if (rd_entry || wr_entry || !but_s) begin
      led_d = '1;
    end else if (led_q != '0) begin
      led_d = led_q - LED_STRETCH_BITS'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= SYNC_IDLE;
      end
      state_q <= IDLE;
      dout_q  <= '0;
      dir_q   <= 1'b0;
      maddr_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      led_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      maddr_q <= maddr_d;
      re_q    <= re_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      led_q   <= led_d;
    end
  end

  assign D_OUT     = dout_q;
  assign DATA_DIR  = dir_q;
  assign mem_addr  = maddr_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign LED1      = (led_q != '0);

`ifdef ACCESS_COUNT_EN
  logic [15:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic        wp_q, wp_d, wp_hit;

  assign wp_hit = (state_q == IDLE) && hit && !wr_s && rd_s && !WRITABLE;

  always_comb begin
    rcnt_d = rcnt_q;
    wcnt_d = wcnt_q;
    wp_d   = wp_q | wp_hit;
    if (rd_entry && (rcnt_q != 16'hFFFF)) begin
      rcnt_d = rcnt_q + 16'd1;
    end
    if (wr_entry && (wcnt_q != 16'hFFFF)) begin
      wcnt_d = wcnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rcnt_q <= '0;
      wcnt_q <= '0;
      wp_q   <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      wcnt_q <= wcnt_d;
      wp_q   <= wp_d;
    end
  end

  assign read_count   = rcnt_q;
  assign write_count  = wcnt_q;
  assign wp_violation = wp_q;
`endif

endmodule

// File: tb/tb_rc2014_mem_window.sv
// Bench for rc2014_mem_window: a writable and a read-only instance share one bus; a timeline model
// built from bus-level latency rules predicts every output per cycle.
module tb_rc2014_mem_window;

  localparam int N = 1024;

  logic        CLK, RST;
  logic [15:0] A;
  logic [7:0]  D_IN;
  logic        MRQ, RD, WR, BUT1;

  logic [7:0]  rw_dout, ro_dout, rw_rdata, ro_rdata, rw_wdata, ro_wdata;
  logic        rw_dir, ro_dir, rw_led, ro_led, rw_re, ro_re, rw_we, ro_we;
  logic [12:0] rw_maddr, ro_maddr;
`ifdef ACCESS_COUNT_EN
  logic [15:0] rw_rc, rw_wc, ro_rc, ro_wc;
  logic        rw_wp, ro_wp;
`endif

  rc2014_mem_window #(.BASE_ADDR(16'h8000), .ADDR_BITS(13), .WRITABLE(1'b1),
                      .SYNC_STAGES(2), .LED_STRETCH_BITS(4)) dut_rw (
    .CLK(CLK), .RST(RST), .A(A), .D_IN(D_IN), .D_OUT(rw_dout), .DATA_DIR(rw_dir),
    .MRQ(MRQ), .RD(RD), .WR(WR), .BUT1(BUT1), .LED1(rw_led),
    .mem_addr(rw_maddr), .mem_re(rw_re), .mem_rdata(rw_rdata), .mem_we(rw_we), .mem_wdata(rw_wdata)
`ifdef ACCESS_COUNT_EN
    , .read_count(rw_rc), .write_count(rw_wc), .wp_violation(rw_wp)
`endif
  );

  rc2014_mem_window #(.BASE_ADDR(16'h8000), .ADDR_BITS(13), .WRITABLE(1'b0),
                      .SYNC_STAGES(2), .LED_STRETCH_BITS(4)) dut_ro (
    .CLK(CLK), .RST(RST), .A(A), .D_IN(D_IN), .D_OUT(ro_dout), .DATA_DIR(ro_dir),
    .MRQ(MRQ), .RD(RD), .WR(WR), .BUT1(BUT1), .LED1(ro_led),
    .mem_addr(ro_maddr), .mem_re(ro_re), .mem_rdata(ro_rdata), .mem_we(ro_we), .mem_wdata(ro_wdata)
`ifdef ACCESS_COUNT_EN
    , .read_count(ro_rc), .write_count(ro_wc), .wp_violation(ro_wp)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input logic [12:0] a);
    return (a == 13'd5) ? 8'hA5 : (a[7:0] ^ 8'h5A);
  endfunction

  // Behavioural memories behind each instance.
  bit         rw_wv [0:8191];
  logic [7:0] rw_wm [0:8191];
  int         rw_we_n = 0, ro_we_n = 0, rw_re_n = 0;
  always @(posedge CLK) begin
    if (rw_re === 1'b1) rw_rdata <= rw_wv[rw_maddr] ? rw_wm[rw_maddr] : init_byte(rw_maddr);
    if (ro_re === 1'b1) ro_rdata <= init_byte(ro_maddr);
    if (rw_we === 1'b1) begin
      rw_wv[rw_maddr] <= 1'b1;
      rw_wm[rw_maddr] <= rw_wdata;
      rw_we_n <= rw_we_n + 1;
    end
    if (ro_we === 1'b1) ro_we_n <= ro_we_n + 1;
    if (rw_re === 1'b1) rw_re_n <= rw_re_n + 1;
  end

  // Timeline model: per-cycle expectations, index = edges counted since time 0.
  bit         exp_dir [0:N-1];
  bit         exp_re  [0:N-1];
  bit         exp_we  [0:N-1];
  bit         dout_chk[0:N-1];
  bit         led_rw  [0:N-1];
  bit         led_ro  [0:N-1];
  logic [12:0] exp_maddr[0:N-1];
  logic [7:0]  exp_wdata[0:N-1];
  logic [7:0]  exp_dout [0:N-1];
  int m_reads = 0, m_writes = 0;
  bit m_wp = 1'b0;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      if (cyc >= N) begin
        chk("model_range", 32'(cyc), 32'(N - 1));
      end else begin
        chk("dir_rw", rw_dir, exp_dir[cyc]);
        chk("dir_ro", ro_dir, exp_dir[cyc]);
        chk("re_rw", rw_re, exp_re[cyc]);
        chk("re_ro", ro_re, exp_re[cyc]);
        chk("we_rw", rw_we, exp_we[cyc]);
        chk("we_ro", ro_we, 1'b0);
        chk("led_rw", rw_led, led_rw[cyc]);
        chk("led_ro", ro_led, led_ro[cyc]);
        if (exp_re[cyc]) begin
          chk("raddr_rw", rw_maddr, exp_maddr[cyc]);
          chk("raddr_ro", ro_maddr, exp_maddr[cyc]);
        end
        if (exp_we[cyc]) begin
          chk("waddr_rw", rw_maddr, exp_maddr[cyc]);
          chk("wdata_rw", rw_wdata, exp_wdata[cyc]);
        end
        if (dout_chk[cyc]) begin
          chk("dout_rw", rw_dout, exp_dout[cyc]);
          chk("dout_ro", ro_dout, exp_dout[cyc]);
        end
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  // LED stretch of 4 bits: lit on the reload edge and the 14 edges after it.
  task automatic led_fill(input bit rw, input int e);
    for (int c = e; c <= e + 14 && c < N; c++) begin
      if (rw) led_rw[c] = 1'b1;
      else    led_ro[c] = 1'b1;
    end
  endtask

  function automatic bit in_win(input logic [15:0] a);
    return a[15:13] == 3'b100;
  endfunction

  // Pins change just after edge n; window entry is seen at edge n+3.
  task automatic rd_begin(input logic [15:0] addr, input int len, output int n);
    n = cyc;
    A = addr; MRQ = 1'b0; RD = 1'b0;
    if (in_win(addr)) begin
      exp_re[n+3] = 1'b1;
      exp_maddr[n+3] = addr[12:0];
      for (int c = n + 4; c <= n + len + 2; c++) exp_dir[c] = 1'b1;
      for (int c = n + 5; c <= n + len + 2; c++) begin
        dout_chk[c] = 1'b1;
        exp_dout[c] = init_byte(addr[12:0]);
      end
      led_fill(1'b1, n + 3);
      led_fill(1'b0, n + 3);
      m_reads++;
    end
  endtask

  task automatic rd_end();
    RD = 1'b1; MRQ = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] addr, input int len, output int n);
    rd_begin(addr, len, n);
    step(len);
    rd_end();
    step(4);
  endtask

  // mrq_lead: MRQ releases first, re-asserts while WR is still low, then both release.
  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input int len, input bit mrq_lead);
    int n, m;
    n = cyc; m = n + len;
    A = addr; D_IN = ~data; MRQ = 1'b0; WR = 1'b0;
    if (in_win(addr)) begin
      led_fill(1'b1, n + 3);
      exp_we[m+3] = 1'b1;
      exp_maddr[m+3] = addr[12:0];
      exp_wdata[m+3] = data;
      m_writes++;
      m_wp = 1'b1;
    end
    step(2);
    D_IN = data;
    step(len - 2);
    if (mrq_lead) begin
      MRQ = 1'b1;
      step(2);
      MRQ = 1'b0;
      step(3);
    end
    WR = 1'b1; MRQ = 1'b1;
    step(6);
  endtask

  int n0, e1, e2, bc;

  initial begin
    RST = 1'b1; A = 16'h0000; D_IN = 8'h00; MRQ = 1'b1; RD = 1'b1; WR = 1'b1; BUT1 = 1'b1;
    step(3);
    chk("rst_dir", rw_dir, 1'b0);
    chk("rst_dout", rw_dout, 8'h00);
    chk("rst_re", rw_re, 1'b0);
    chk("rst_we", rw_we, 1'b0);
    chk("rst_maddr", rw_maddr, 13'h0000);
    chk("rst_wdata", rw_wdata, 8'h00);
    chk("rst_led", rw_led, 1'b0);
    RST = 1'b0;
    chk_en = 1'b1;
    step(2);

    // Read 0x8005 with literal latency pins.
    rd_begin(16'h8005, 6, n0);
    step(3);
    chk("t1_re", rw_re, 1'b1);
    chk("t1_addr", rw_maddr, 13'h0005);
    chk("t1_dir_early", rw_dir, 1'b0);
    step(1);
    chk("t1_dir_rise", rw_dir, 1'b1);
    chk("t1_re_once", rw_re, 1'b0);
    step(1);
    chk("t1_dout", rw_dout, 8'hA5);
    step(1);
    rd_end();
    step(2);
    chk("t1_dir_hold", rw_dir, 1'b1);
    step(1);
    chk("t1_dir_fall", rw_dir, 1'b0);
    step(17);

    // Out-of-window reads on either side.
    do_read(16'h7FFF, 5, n0);
    do_read(16'hA000, 5, n0);
    chk("t2_re_cnt", 32'(rw_re_n), 32'd1);
    chk("t2_led", rw_led, 1'b0);

    // Writes: plain release, then MRQ-first with re-assert while WR is held.
    do_write(16'h9FFF, 8'h3C, 6, 1'b0);
    chk("t3_we_cnt", 32'(rw_we_n), 32'd1);
    chk("t3_mem", rw_wm[13'h1FFF], 8'h3C);
    chk("t3_ro_we", 32'(ro_we_n), 32'd0);
`ifdef ACCESS_COUNT_EN
    chk("t3_wp_ro", ro_wp, 1'b1);
    chk("t3_wp_rw", rw_wp, 1'b0);
`endif
    step(16);
    do_write(16'h8010, 8'hC3, 5, 1'b1);
    chk("t3_we_cnt2", 32'(rw_we_n), 32'd2);
    chk("t3_mem2", rw_wm[13'h0010], 8'hC3);
    step(16);

    // Both strobes low: no access at all.
    A = 16'h8000; MRQ = 1'b0; RD = 1'b0; WR = 1'b0;
    step(6);
    RD = 1'b1; WR = 1'b1; MRQ = 1'b1;
    step(4);
    chk("t4_re_cnt", 32'(rw_re_n), 32'd1);
    chk("t4_we_cnt", 32'(rw_we_n), 32'd2);
    step(16);

    // LED stretch, retrigger, and button hold.
    do_read(16'h8001, 6, n0);
    e1 = n0 + 3;
    wait_until(e1 + 14);
    chk("t6_led_last", rw_led, 1'b1);
    step(1);
    chk("t6_led_off", rw_led, 1'b0);
    step(2);
    do_read(16'h8001, 6, n0);
    e1 = n0 + 3;
    do_read(16'h8002, 6, n0);
    e2 = n0 + 3;
    chk("t6_gap", 32'(e2 - e1), 32'd10);
    wait_until(e2 + 14);
    chk("t6_retrig_on", rw_led, 1'b1);
    step(1);
    chk("t6_retrig_off", rw_led, 1'b0);
    bc = cyc;
    BUT1 = 1'b0;
    for (int e = bc + 3; e <= bc + 32; e++) begin
      led_fill(1'b1, e);
      led_fill(1'b0, e);
    end
    step(25);
    chk("t6_but_hold", rw_led, 1'b1);
    step(5);
    BUT1 = 1'b1;
    step(20);

    // Reset in the middle of a driven read.
    rd_begin(16'h8007, 30, n0);
    step(6);
    chk("t5_dir_pre", rw_dir, 1'b1);
    chk_en = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk("t5_dir_rw", rw_dir, 1'b0);
    chk("t5_dir_ro", ro_dir, 1'b0);
    chk("t5_led_rw", rw_led, 1'b0);
    chk("t5_led_ro", ro_led, 1'b0);
    chk("t5_dout", rw_dout, 8'h00);
    for (int c = cyc; c < N; c++) begin
      exp_dir[c] = 1'b0; exp_re[c] = 1'b0; exp_we[c] = 1'b0;
      dout_chk[c] = 1'b0; led_rw[c] = 1'b0; led_ro[c] = 1'b0;
    end
    m_reads = 0; m_writes = 0; m_wp = 1'b0;
    RD = 1'b1; MRQ = 1'b1;
    step(2);
    RST = 1'b0;
    chk_en = 1'b1;
    step(2);
    do_read(16'h8005, 6, n0);
    step(4);

`ifdef ACCESS_COUNT_EN
    chk("cnt_rd_rw", rw_rc, 16'(m_reads));
    chk("cnt_rd_ro", ro_rc, 16'(m_reads));
    chk("cnt_wr_rw", rw_wc, 16'(m_writes));
    chk("cnt_wr_ro", ro_wc, 16'h0000);
    chk("wp_ro_end", ro_wp, m_wp);
`endif
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc2014_mem_window.md
Name: rc2014_mem_window

Overview:
Parametrised Z80/RC2014 bus memory responder. Decodes a power-of-two address window, serves reads from an external synchronous on-chip memory port and, when enabled, forwards writes to it. Drives the data-bus output enable and an activity LED. It sits between the RC2014 bus pins (through the SB_IO data pads) and a block-RAM/ROM instance.

Parameters:
BASE_ADDR, 16'h0000, window base; aligned to 2^ADDR_BITS, low ADDR_BITS bits ignored
ADDR_BITS, 13, window size 2^ADDR_BITS bytes; legal range 8..15
WRITABLE, 0, 1 = forward bus writes to memory; 0 = read-only (ROM)
SYNC_STAGES, 2, flip-flop stages on A, D_IN, MRQ, RD, WR; minimum 2
LED_STRETCH_BITS, 24, width of the LED stretch counter

Ports:
CLK  in  1  system clock
RST  in  1  reset; asynchronous, active-high
A  in  16  bus address
D_IN  in  8  bus data from pad
D_OUT  out  8  bus data to pad
DATA_DIR  out  1  pad output enable; 1 = drive bus
MRQ  in  1  memory request, active-low
RD  in  1  read strobe, active-low
WR  in  1  write strobe, active-low
BUT1  in  1  LED test button, active-low
LED1  out  1  activity LED, active-high
mem_addr  out  ADDR_BITS  memory address (A minus window base)
mem_re  out  1  memory read strobe; data valid the cycle after
mem_rdata  in  8  memory read data
mem_we  out  1  memory write strobe, one-cycle pulse
mem_wdata  out  8  memory write data

Behaviour:
- Reset (async): state IDLE; D_OUT=0, DATA_DIR=0, mem_addr=0, mem_re=0, mem_we=0, mem_wdata=0, LED counter=0 (LED1=0), sync chains cleared to the idle value (strobes=1, A/D=0).
- All bus inputs pass through SYNC_STAGES registers; "synced" below means the chain output.
- hit = synced A[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS] && synced MRQ==0.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: hit && RD==0 && WR==1 -> READ; mem_addr<=A[ADDR_BITS-1:0]; mem_re<=1 for exactly one cycle. hit && WR==0 && RD==1 && WRITABLE -> WRITE; mem_addr latched. RD and WR both 0: illegal, no transition. In-window write with WRITABLE=0: ignored, stays IDLE, no LED trigger.
- READ: the cycle after mem_re, D_OUT<=mem_rdata and DATA_DIR<=1. The address is latched at entry and not re-evaluated. When synced RD==1 or MRQ==1: DATA_DIR<=0 and -> IDLE. Latency: DATA_DIR rises SYNC_STAGES+2 edges after RD/MRQ falls at pins and falls SYNC_STAGES+1 edges after the strobe rises.
- WRITE: mem_wdata<=synced D_IN every cycle while WR==0. When synced WR==1 or MRQ==1: mem_we pulses 1 cycle with the last captured data -> DONE.
- DONE: mem_we=0; return to IDLE only once synced WR==1 && RD==1. This blocks a double write.
- DATA_DIR is never 1 outside READ.
- LED: the counter reloads to all-ones on any entry to READ/WRITE, and on BUT1==0 (synced via the same chain), including while nonzero (retrigger). Otherwise it decrements to 0 and saturates there. LED1 = counter != 0.

Optional Feature:
ACCESS_COUNT_EN: when defined, adds outputs read_count[15:0] and write_count[15:0]. Each increments once per READ or WRITE entry, saturates at 16'hFFFF, and clears on RST. A third output, wp_violation (1 bit, sticky until RST), sets on an in-window write when WRITABLE=0. When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. BASE=16'h8000, ADDR_BITS=13, mem[5]=8'hA5. Read 0x8005 -> one mem_re with mem_addr=13'h0005; DATA_DIR high 4 edges after RD low, D_OUT=8'hA5; DATA_DIR low 3 edges after RD high.
2. Reads at 0x7FFF and 0xA000 -> no mem_re, DATA_DIR stays 0, LED1 unchanged.
3. WRITABLE=1: write 8'h3C to 0x9FFF -> exactly one mem_we, mem_addr=13'h1FFF, mem_wdata=8'h3C after WR rises. WRITABLE=0: no mem_we; with ACCESS_COUNT_EN, wp_violation=1.
4. RD=0 and WR=0 together at 0x8000 -> no mem_re, no mem_we, DATA_DIR=0.
5. RST asserted mid-read with DATA_DIR=1 -> DATA_DIR=0 and LED1=0 with no clock edge; after release, next read works normally.
6. LED_STRETCH_BITS=4: a single hit -> LED1 high 15 cycles; a second hit at cycle 10 -> LED1 extends to 15 cycles after it. With BUT1 held low, LED1 stays high.
